// File: rtl/rr_stream_word_packer_pkg.sv
// Shared record/replay packing types: PCIM word width, packer flush states and
// the LSB mask helper that the replay unpacker also uses.
package rr_stream_word_packer_pkg;

  localparam int unsigned RR_PCIM_WORD_WIDTH = 512;
  // Widest logging unit any rr_lsb_mask caller may request.
  localparam int unsigned RR_MAX_UNIT_WIDTH = 1024;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    PAD,
    DONE
  } rr_word_packer_state_t;

  function automatic logic [RR_MAX_UNIT_WIDTH-1:0] rr_lsb_mask(input int unsigned len);
    logic [RR_MAX_UNIT_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < RR_MAX_UNIT_WIDTH; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_stream_word_packer.sv
// Packs variable-length logging units LSB-first into fixed OUT_WIDTH-bit words,
// with a flush that zero-pads and emits the final partial word.
module rr_stream_word_packer
  import rr_stream_word_packer_pkg::*;
#(
  parameter int unsigned FULL_WIDTH   = 512,
  parameter int unsigned OUT_WIDTH    = RR_PCIM_WORD_WIDTH,
  parameter int unsigned OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
  parameter int unsigned FILL_WIDTH   = $clog2(OUT_WIDTH + FULL_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [FULL_WIDTH-1:0]   in_data,
  input  logic [OFFSET_WIDTH-1:0] in_len,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [OUT_WIDTH-1:0]    out_data,
  input  logic                    out_ready,
  input  logic                    flush_req,
  output logic                    flush_busy,
  output logic                    flush_done,
  output logic [63:0]             word_cnt,
  output logic [63:0]             bit_cnt
);

  localparam int unsigned BUF_WIDTH = OUT_WIDTH + FULL_WIDTH;
  localparam logic [FILL_WIDTH-1:0] OUT_FILL = FILL_WIDTH'(OUT_WIDTH);

  if (FULL_WIDTH < 1 || FULL_WIDTH > OUT_WIDTH) begin : g_bad_full_width
    $error("rr_stream_word_packer: FULL_WIDTH must be in 1..OUT_WIDTH");
  end
  if ((OUT_WIDTH & (OUT_WIDTH - 1)) != 0) begin : g_bad_out_width
    $error("rr_stream_word_packer: OUT_WIDTH must be a power of two");
  end
  if (FULL_WIDTH > RR_MAX_UNIT_WIDTH) begin : g_bad_mask_width
    $error("rr_stream_word_packer: FULL_WIDTH exceeds rr_lsb_mask width");
  end

  rr_word_packer_state_t state, state_n;
  logic [BUF_WIDTH-1:0]  residue, residue_n, shifted, unit_ext;
  logic [FILL_WIDTH-1:0] fill, fill_n, fill_s;
  logic [FULL_WIDTH-1:0] unit;
  logic                  hs_i, hs_o, out_valid_n;

  assign hs_o     = out_valid && out_ready;
  assign in_ready = !rst && (state == RUN) && ((fill < OUT_FILL) || hs_o);
  assign hs_i     = in_valid && in_ready;
  assign unit     = in_data & FULL_WIDTH'(rr_lsb_mask(32'(in_len)));
  assign unit_ext = BUF_WIDTH'(unit);

  // Bits of residue at or above fill are always zero, so the low word is
  // already the zero-padded residue when PAD presents it.
  always_comb begin
    shifted     = hs_o ? (residue >> OUT_WIDTH) : residue;
    fill_s      = hs_o ? (fill - OUT_FILL) : fill;
    residue_n   = shifted;
    fill_n      = fill_s;
    state_n     = state;
    unique case (state)
      RUN: begin
        if (hs_i) begin
          residue_n = shifted | (unit_ext << fill_s);
          fill_n    = fill_s + FILL_WIDTH'(in_len);
        end
        if (flush_req) state_n = DRAIN;
      end
      DRAIN: begin
        if (!out_valid || hs_o) state_n = (fill_s != '0) ? PAD : DONE;
      end
      PAD: begin
        if (hs_o) begin
          residue_n = '0;
          fill_n    = '0;
          state_n   = DONE;
        end
      end
      DONE: state_n = RUN;
    endcase
    out_valid_n = (state_n == PAD) || (fill_n >= OUT_FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      residue    <= '0;
      fill       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      word_cnt   <= '0;
      bit_cnt    <= '0;
    end else begin
      state      <= state_n;
      residue    <= residue_n;
      fill       <= fill_n;
      out_valid  <= out_valid_n;
      out_data   <= residue_n[OUT_WIDTH-1:0];
      flush_busy <= (state_n != RUN);
      flush_done <= (state_n == DONE);
      if (hs_o) word_cnt <= word_cnt + 64'd1;
      if (hs_i) bit_cnt <= bit_cnt + 64'(in_len);
    end
  end

endmodule
